// File: rtl/nibble_add_sequencer.sv
// Wide add/subtract sequenced through one shared 4-bit adder slice.
// Operands are processed LSB nibble first; the carry is threaded through a register.
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
  input  logic                   sub,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   overflow,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_d;
  logic            load;
  logic            step;
  logic            last;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;

  assign last = (idx == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  // Nibble select by shifting keeps the index arithmetic width-clean.
  assign a_nib = 4'(a_q >> {idx, 2'b00});
  assign b_nib = 4'(b_q >> {idx, 2'b00});

  assign add_a   = busy ? a_nib : 4'h0;
  assign add_b   = busy ? b_nib : 4'h0;
  assign add_cin = busy ? carry : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      idx    <= '0;
      a_q    <= op_a;
      b_q    <= sub ? ~op_b : op_b;
      carry  <= sub | op_cin;
      result <= '0;
    end else if (step) begin
      carry <= add_cout;
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx == IW'(i)) begin
          result[4*i +: 4] <= add_sum;
        end
      end
      if (last) begin
        cout     <= add_cout;
        // MSB carry-in is recovered from the top bit's sum.
        overflow <= a_q[W-1] ^ b_q[W-1] ^ add_sum[3] ^ add_cout;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Bench for nibble_add_sequencer: vector table, scoreboard on done,
// plus hand sequences for start-while-busy, reset abort and back-to-back.
module tb_nibble_add_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         sub;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_done = 1'b0;
  vec_t vt[11];

  nibble_add_sequencer #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_cin   (op_cin),
    .sub      (sub),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t tv(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic sb_,
                              input logic [W-1:0] r, input logic co,
                              input logic ov);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sb_;
    v.r = r; v.co = co; v.ov = ov;
    return v;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic sb_);
    logic [W-1:0] be;
    logic [W:0]   s;
    logic         c0;
    be = sb_ ? ~b : b;
    c0 = sb_ ? 1'b1 : cin;
    s  = {1'b0, a} + {1'b0, be} + (W+1)'(c0);
    return tv(a, b, cin, sb_, s[W-1:0], s[W],
              (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]));
  endfunction

  always @(negedge clk) begin
    if (done) begin
      chk("done_width", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no done");
      end else begin
        mon_e = sb.pop_front();
        chk("result", 32'(result), 32'(mon_e.r));
        chk("cout", 32'(cout), 32'(mon_e.co));
        chk("overflow", 32'(overflow), 32'(mon_e.ov));
        chk("latency", 32'(cyc - mon_e.acc), 32'(N + 1));
      end
    end
    prev_done = done;
  end

  task automatic issue(input vec_t v, output int acc);
    exp_t e;
    @(negedge clk);
    op_a = v.a; op_b = v.b; op_cin = v.cin; sub = v.sub;
    start = 1'b1;
    acc = -1;
    for (int n = 0; n < 3 * N + 10; n++) begin
      if (ready) break;
      @(negedge clk);
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready=0 want 1");
    end else begin
      acc = cyc;
      e.r = v.r; e.co = v.co; e.ov = v.ov; e.acc = cyc;
      sb.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int           acc;
    logic [W-1:0] be;
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    logic [4:0]   s5;
    logic         c;
    be = v.sub ? ~v.b : v.b;
    c  = v.sub ? 1'b1 : v.cin;
    issue(v, acc);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      start = 1'b0;
      ta = v.a >> (4 * k);
      tb = be >> (4 * k);
      chk("run_busy", 32'(busy), 32'd1);
      chk("add_a", 32'(add_a), 32'(ta[3:0]));
      chk("add_b", 32'(add_b), 32'(tb[3:0]));
      chk("add_cin", 32'(add_cin), 32'(c));
      s5 = 5'(ta[3:0]) + 5'(tb[3:0]) + 5'(c);
      c  = s5[4];
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_ready", 32'(ready), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_add_a", 32'(add_a), 32'd0);
    @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc1;
    int   acc2;
    int   accs[3];
    vec_t v;

    vt[0] = tv(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    vt[1] = tv(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    vt[2] = tv(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    vt[3] = tv(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    vt[4] = tv(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    vt[5] = tv(16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    vt[6] = tv(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    for (int i = 7; i < 11; i++) begin
      vt[i] = mk(16'($urandom), 16'($urandom), 1'($urandom),
                 1'($urandom));
    end

    rst = 1'b1; start = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_vec(vt[i]);
    end

    // start held through RUN and DONE with different operands
    issue(vt[0], acc1);
    v = mk(16'hAAAA, 16'h5555, 1'b0, 1'b1);
    issue(v, acc2);
    chk("restart_gap", 32'(acc2 - acc1), 32'(N + 2));
    @(negedge clk);
    start = 1'b0;
    repeat (N + 3) @(negedge clk);

    // reset in the second RUN cycle aborts without done
    issue(vt[1], acc1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    chk("abort_add", 32'({add_a, add_b, add_cin}), 32'd0);
    repeat (N + 3) @(negedge clk);
    run_vec(vt[6]);

    // back-to-back with start held high
    for (int i = 0; i < 3; i++) begin
      issue(vt[7 + i], accs[i]);
      if (i > 0) begin
        chk("b2b_gap", 32'(accs[i] - accs[i-1]), 32'(N + 2));
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (N + 3) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
